obi_axi_master: RTL and testbench

Single-outstanding bridge from the CV32E40P OBI-style instruction/data port to an AXI4 master port. It is the initiator that drives the `instr` and `data` slave ports of the AXI memory subsystem: one instance per core port. Each accepted core request becomes exactly one single-beat AXI4 transaction. The AXI response returns to the core as a one-cycle `rvalid_o` pulse.

---
 rtl/obi_axi_master_if.sv | 86 ++++++++
 rtl/obi_axi_master.sv | 200 ++++++++++++++++++++
 tb/tb_obi_axi_master.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_axi_master_if.sv
// AXI4 bus bundle shared by the OBI bridge and its AXI peers.
// Master drives requests and response readies; Slave the reverse.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 16,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]         w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        output aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
        output aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        output ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        input aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
        input aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        input ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input r_ready
    );
endinterface

// File: rtl/obi_axi_master.sv
// Single-outstanding OBI core port to AXI4 single-beat master bridge.
// Define OBI_AXI_MASTER_ALIGN_CHK_EN to reject misaligned requests locally.
module obi_axi_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 16,
    parameter int unsigned AXI_USER_WIDTH = 10,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    AXI_BUS.Master      axi
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

`ifdef OBI_AXI_MASTER_ALIGN_CHK_EN
    typedef enum logic [2:0] {
        IDLE, WR, WR_B, RD_AR, RD_R, ERR
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE, WR, WR_B, RD_AR, RD_R
    } state_e;
`endif

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [STRB_W-1:0]         be_q, be_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

    assign gnt_o = req_i && (state_q == IDLE);

    // Channel valids/readies decode from registered state only, never from a ready.
    assign aw_valid = (state_q == WR) && !aw_done_q;
    assign w_valid  = (state_q == WR) && !w_done_q;
    assign ar_valid = (state_q == RD_AR);
    assign b_ready  = (state_q == WR_B);
    assign r_ready  = (state_q == RD_R);

    assign aw_hs = aw_valid && axi.aw_ready;
    assign w_hs  = w_valid && axi.w_ready;
    assign ar_hs = ar_valid && axi.ar_ready;
    assign b_hs  = b_ready && axi.b_valid;
    assign r_hs  = r_ready && axi.r_valid;

    assign axi.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi.aw_addr   = addr_q;
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = 3'b010;
    assign axi.aw_burst  = 2'b01;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'd0;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_qos    = 4'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_atop   = 6'd0;
    assign axi.aw_user   = AXI_USER_WIDTH'(0);
    assign axi.aw_valid  = aw_valid;

    assign axi.w_data  = wdata_q;
    assign axi.w_strb  = be_q;
    assign axi.w_last  = 1'b1;
    assign axi.w_user  = AXI_USER_WIDTH'(0);
    assign axi.w_valid = w_valid;

    assign axi.b_ready = b_ready;

    assign axi.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi.ar_addr   = addr_q;
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = 3'b010;
    assign axi.ar_burst  = 2'b01;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'd0;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_qos    = 4'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_user   = AXI_USER_WIDTH'(0);
    assign axi.ar_valid  = ar_valid;

    assign axi.r_ready = r_ready;

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // Next-state and response capture for the single-transaction FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d    = addr_i;
                    be_d      = be_i;
                    wdata_d   = wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = we_i ? WR : RD_AR;
`ifdef OBI_AXI_MASTER_ALIGN_CHK_EN
                    if (addr_i[1:0] != 2'b00) begin
                        state_d = ERR;
                    end
`endif
                end
            end
            WR: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                if (b_hs) begin
                    rvalid_d = 1'b1;
                    err_d    = axi.b_resp[1];
                    state_d  = IDLE;
                end
            end
            RD_AR: begin
                if (ar_hs) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                if (r_hs) begin
                    rvalid_d = 1'b1;
                    rdata_d  = axi.r_data;
                    err_d    = axi.r_resp[1];
                    state_d  = IDLE;
                end
            end
`ifdef OBI_AXI_MASTER_ALIGN_CHK_EN
            ERR: begin
                rvalid_d = 1'b1;
                rdata_d  = 32'd0;
                err_d    = 1'b1;
                state_d  = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request and registered response; reset aborts any transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_obi_axi_master.sv
// Bench for obi_axi_master: small AXI memory slave plus directed vectors.
module tb_obi_axi_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic        w_ready_tb = 1'b1;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    AXI_BUS #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10)
    ) axi_if ();

    obi_axi_master #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10), .AXI_ID(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .axi(axi_if)
    );

    // ---------------- AXI memory slave ----------------
    logic [31:0] mem [0:255] = '{default: 32'h0};
    logic        have_aw, have_w, bv, rv;
    logic [1:0]  br, rr;
    logic [31:0] sa, sd, rd_s;
    logic [3:0]  ss;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int max_out = 0;
    logic [31:0] last_aw_addr, last_ar_addr;
    logic [7:0]  last_aw_len;
    logic [2:0]  last_aw_size;
    logic [1:0]  last_aw_burst;
    logic [3:0]  last_w_strb;
    logic        last_w_last;

    wire aw_hs = axi_if.aw_valid && axi_if.aw_ready;
    wire w_hs  = axi_if.w_valid && axi_if.w_ready;
    wire ar_hs = axi_if.ar_valid && axi_if.ar_ready;
    wire b_hs  = axi_if.b_valid && axi_if.b_ready;
    wire r_hs  = axi_if.r_valid && axi_if.r_ready;
    wire [31:0] wa = have_aw ? sa : axi_if.aw_addr;
    wire [31:0] wd = have_w ? sd : axi_if.w_data;
    wire [3:0]  ws = have_w ? ss : axi_if.w_strb;

    assign axi_if.aw_ready = 1'b1;
    assign axi_if.w_ready  = w_ready_tb;
    assign axi_if.ar_ready = 1'b1;
    assign axi_if.b_valid  = bv;
    assign axi_if.b_resp   = br;
    assign axi_if.b_id     = '0;
    assign axi_if.b_user   = '0;
    assign axi_if.r_valid  = rv;
    assign axi_if.r_data   = rd_s;
    assign axi_if.r_resp   = rr;
    assign axi_if.r_last   = 1'b1;
    assign axi_if.r_id     = '0;
    assign axi_if.r_user   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            bv      <= 1'b0;
            rv      <= 1'b0;
            br      <= 2'b00;
            rr      <= 2'b00;
            rd_s    <= '0;
        end else begin
            if (aw_hs) begin
                aw_cnt        <= aw_cnt + 1;
                last_aw_addr  <= axi_if.aw_addr;
                last_aw_len   <= axi_if.aw_len;
                last_aw_size  <= axi_if.aw_size;
                last_aw_burst <= axi_if.aw_burst;
                have_aw       <= 1'b1;
                sa            <= axi_if.aw_addr;
            end
            if (w_hs) begin
                w_cnt       <= w_cnt + 1;
                last_w_strb <= axi_if.w_strb;
                last_w_last <= axi_if.w_last;
                have_w      <= 1'b1;
                sd          <= axi_if.w_data;
                ss          <= axi_if.w_strb;
            end
            if (b_hs) begin
                bv    <= 1'b0;
                b_cnt <= b_cnt + 1;
            end
            if ((have_aw || aw_hs) && (have_w || w_hs) && !bv) begin
                if (wa < 32'h400) begin
                    for (int k = 0; k < 4; k++)
                        if (ws[k]) mem[wa[9:2]][8*k +: 8] <= wd[8*k +: 8];
                    br <= 2'b00;
                end else begin
                    br <= 2'b11;
                end
                bv      <= 1'b1;
                have_aw <= 1'b0;
                have_w  <= 1'b0;
            end
            if (r_hs) begin
                rv    <= 1'b0;
                r_cnt <= r_cnt + 1;
            end
            if (ar_hs) begin
                ar_cnt       <= ar_cnt + 1;
                last_ar_addr <= axi_if.ar_addr;
                rv           <= 1'b1;
                if (axi_if.ar_addr < 32'h400) begin
                    rd_s <= mem[axi_if.ar_addr[9:2]];
                    rr   <= 2'b00;
                end else begin
                    rd_s <= 32'h0BAD_0BAD;
                    rr   <= 2'b11;
                end
            end
        end
    end

    always @(negedge clk)
        if (ar_cnt - r_cnt > max_out) max_out <= ar_cnt - r_cnt;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] rd, output logic er);
        int n;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        n = 0;
        while (!gnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!gnt) begin
            chk("gnt_timeout", 32'd0, 32'd1);
            req = 1'b0;
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            req = 1'b0;
            n++;
        end while (!rvalid && n < 30);
        if (rvalid) begin
            lat = n;
            rd  = rdata;
            er  = err;
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic        ck_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt [10];
    int lat;
    logic [31:0] rdv;
    logic er;

    initial begin
        vt[0] = '{1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 3};
        vt[1] = '{1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3};
        vt[2] = '{1'b0, 32'h3000_0000, 4'hF, 32'h0, 1'b1, 32'h0BAD0BAD, 1'b1, 3};
        vt[3] = '{1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3};
        vt[4] = '{1'b1, 32'h104, 4'b0011, 32'h12345678, 1'b0, 32'h0, 1'b0, 3};
        vt[5] = '{1'b0, 32'h104, 4'hF, 32'h0, 1'b1, 32'h00005678, 1'b0, 3};
        vt[6] = '{1'b1, 32'h108, 4'b1100, 32'hAABBCCDD, 1'b0, 32'h0, 1'b0, 3};
        vt[7] = '{1'b0, 32'h108, 4'hF, 32'h0, 1'b1, 32'hAABB0000, 1'b0, 3};
        vt[8] = '{1'b1, 32'h3000_0010, 4'hF, 32'h1, 1'b0, 32'h0, 1'b1, 3};
        vt[9] = '{1'b0, 32'h104, 4'hF, 32'h0, 1'b1, 32'h00005678, 1'b0, 3};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {24'd0, gnt, rvalid, err, axi_if.aw_valid, axi_if.w_valid,
                         axi_if.ar_valid, axi_if.b_ready, axi_if.r_ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            do_txn(vt[i].w, vt[i].a, vt[i].b, vt[i].d, lat, rdv, er);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            if (vt[i].ck_rd)
                chk($sformatf("v%0d_rdata", i), rdv, vt[i].exp_rd);
            chk($sformatf("v%0d_addr", i), vt[i].w ? last_aw_addr : last_ar_addr, vt[i].a);
            if (i == 0) begin
                chk("aw_len", {24'd0, last_aw_len}, 32'd0);
                chk("aw_size", {29'd0, last_aw_size}, 32'd2);
                chk("aw_burst", {30'd0, last_aw_burst}, 32'd1);
                chk("w_strb", {28'd0, last_w_strb}, 32'hF);
                chk("w_last", {31'd0, last_w_last}, 32'd1);
            end
        end

        // skewed write: W ready low for 5 cycles, AW accepted at once
        begin
            int bad, aw0, w0, b0;
            bad = 0; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
            @(negedge clk);
            w_ready_tb = 1'b0;
            req = 1'b1; we = 1'b1; addr = 32'h10C; be = 4'hF; wdata = 32'h55AA55AA;
            #1;
            chk("skew_gnt", {31'd0, gnt}, 32'd1);
            @(negedge clk);
            req = 1'b0;
            chk("skew_c1_valids", {30'd0, axi_if.aw_valid, axi_if.w_valid}, 32'd3);
            for (int c = 2; c <= 5; c++) begin
                @(negedge clk);
                if (axi_if.aw_valid || !axi_if.w_valid || axi_if.b_ready) bad++;
            end
            chk("skew_hold", 32'(bad), 32'd0);
            @(negedge clk);
            w_ready_tb = 1'b1;
            chk("skew_c6_wvalid", {31'd0, axi_if.w_valid}, 32'd1);
            @(negedge clk);
            chk("skew_c7", {29'd0, axi_if.b_ready, axi_if.w_valid, rvalid}, 32'd4);
            @(negedge clk);
            chk("skew_rvalid", {30'd0, rvalid, err}, 32'd2);
            repeat (3) @(negedge clk);
            chk("skew_aw_cnt", 32'(aw_cnt - aw0), 32'd1);
            chk("skew_w_cnt", 32'(w_cnt - w0), 32'd1);
            chk("skew_b_cnt", 32'(b_cnt - b0), 32'd1);
            do_txn(1'b0, 32'h10C, 4'hF, 32'h0, lat, rdv, er);
            chk("skew_readback", rdv, 32'h55AA55AA);
        end

        // back-to-back reads with req held high
        begin
            logic [31:0] ba [4];
            logic [31:0] bd [4];
            int gc, rc, bad, dbad;
            logic g, r;
            ba[0] = 32'h100; ba[1] = 32'h104; ba[2] = 32'h108; ba[3] = 32'h10C;
            bd[0] = 32'hDEADBEEF; bd[1] = 32'h00005678;
            bd[2] = 32'hAABB0000; bd[3] = 32'h55AA55AA;
            gc = 0; rc = 0; bad = 0; dbad = 0;
            @(negedge clk);
            req = 1'b1; we = 1'b0; addr = ba[0]; be = 4'hF;
            for (int c = 0; c < 40 && rc < 4; c++) begin
                #1;
                g = gnt;
                r = rvalid;
                if (r) begin
                    if (rdata !== bd[rc]) dbad++;
                    rc++;
                end
                if (g) begin
                    if (gc > 0 && !r) bad++;
                    gc++;
                end
                @(negedge clk);
                if (g) begin
                    if (gc >= 4) req = 1'b0;
                    else addr = ba[gc];
                end
            end
            req = 1'b0;
            repeat (4) @(negedge clk);
            chk("b2b_gnt_cnt", 32'(gc), 32'd4);
            chk("b2b_rvalid_cnt", 32'(rc), 32'd4);
            chk("b2b_gnt_with_rvalid", 32'(bad), 32'd0);
            chk("b2b_rdata", 32'(dbad), 32'd0);
            chk("b2b_max_outstanding", 32'(max_out), 32'd1);
        end

        // misaligned read
        begin
            int ar0;
            ar0 = ar_cnt;
            do_txn(1'b0, 32'h102, 4'hF, 32'h0, lat, rdv, er);
`ifdef OBI_AXI_MASTER_ALIGN_CHK_EN
            chk("mis_lat", 32'(lat), 32'd2);
            chk("mis_err", {31'd0, er}, 32'd1);
            chk("mis_rdata", rdv, 32'd0);
            chk("mis_no_ar", 32'(ar_cnt - ar0), 32'd0);
`else
            chk("mis_lat", 32'(lat), 32'd3);
            chk("mis_err", {31'd0, er}, 32'd0);
            chk("mis_ar_addr", last_ar_addr, 32'h102);
            chk("mis_ar_cnt", 32'(ar_cnt - ar0), 32'd1);
`endif
        end

        // reset in the middle of a write
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h110; be = 4'hF; wdata = 32'h1;
        @(negedge clk);
        req = 1'b0;
        chk("mid_wr_active", {31'd0, axi_if.aw_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {24'd0, gnt, rvalid, err, axi_if.aw_valid, axi_if.w_valid,
                             axi_if.ar_valid, axi_if.b_ready, axi_if.r_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1'b0, 32'h100, 4'hF, 32'h0, lat, rdv, er);
        chk("post_rst_lat", 32'(lat), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
